// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared state and mode definitions for timer_ctrl
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl_counter.sv
// rtl/timer_ctrl_counter.sv - shared up-counter with synchronous clear (clear beats enable)
module timer_ctrl_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - one-shot/periodic timer FSM; optional prescaler under TIMER_CTRL_PRESCALE_EN
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      mode_i,
  input  logic [CNT_WIDTH-1:0]      period_i,
`ifdef TIMER_CTRL_PRESCALE_EN
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
`endif
  output logic                      busy_o,
  output logic                      tick_o,
  output logic                      done_o,
  output logic [CNT_WIDTH-1:0]      count_o
);

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] count;
  logic                 mode_q;
  logic                 count_en;
  logic                 term;
  logic                 start_ok;

  // Start is only accepted outside RUN, and a simultaneous stop always wins.
  assign start_ok = start_i && !stop_i && (state != RUN);

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] presc_cnt;

  assign count_en = (state == RUN) && (presc_cnt == prescale_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_cnt <= '0;
    end else if (state != RUN || stop_i || count_en) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prescale_q <= '0;
    end else if (start_ok) begin
      prescale_q <= prescale_i;
    end
  end
`else
  assign count_en = (state == RUN);
`endif

  assign term   = count_en && (count == period_q - CNT_WIDTH'(1));
  assign tick_o = term && !stop_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
    end else if (start_ok) begin
      period_q <= (period_i == '0) ? CNT_WIDTH'(1) : period_i;
      mode_q   <= mode_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = RUN;
      RUN: begin
        if (stop_i)                             state_next = IDLE;
        else if (term && mode_q == MODE_ONESHOT) state_next = DONE;
      end
      DONE: begin
        if (stop_i)        state_next = IDLE;
        else if (start_ok) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  timer_ctrl_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_count (
    .clk   (clk_i),
    .resetn(~rst_i),
    .en    (count_en),
    .clr   (term || start_ok || stop_i),
    .count (count)
  );

  assign busy_o  = (state == RUN);
  assign done_o  = (state == DONE);
  assign count_o = count;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed self-checking bench for timer_ctrl
module tb_timer_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stop_i;
  logic        mode_i;
  logic [15:0] period_i;
`ifdef TIMER_CTRL_PRESCALE_EN
  logic [7:0]  prescale_i;
`endif
  logic        busy_o;
  logic        tick_o;
  logic        done_o;
  logic [15:0] count_o;

  int n_assert = 0;
  int n_fail   = 0;

  timer_ctrl #(
    .CNT_WIDTH     (16),
    .PRESCALE_WIDTH(8)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .mode_i    (mode_i),
    .period_i  (period_i),
`ifdef TIMER_CTRL_PRESCALE_EN
    .prescale_i(prescale_i),
`endif
    .busy_o    (busy_o),
    .tick_o    (tick_o),
    .done_o    (done_o),
    .count_o   (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic b, input logic t, input logic d,
                         input logic [15:0] c);
    chk({tag, " busy"}, {31'd0, busy_o}, {31'd0, b});
    chk({tag, " tick"}, {31'd0, tick_o}, {31'd0, t});
    chk({tag, " done"}, {31'd0, done_o}, {31'd0, d});
    chk({tag, " count"}, {16'd0, count_o}, {16'd0, c});
  endtask

  // Advance to the next cycle and release single-cycle request pulses.
  task automatic step();
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  task automatic launch(input logic m, input logic [15:0] p);
    mode_i   = m;
    period_i = p;
    start_i  = 1'b1;
    step();
  endtask

  initial begin
    logic [15:0] exp_cnt [10];
    logic        exp_tck [10];

    rst_i    = 1'b1;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    mode_i   = 1'b0;
    period_i = 16'd0;
`ifdef TIMER_CTRL_PRESCALE_EN
    prescale_i = 8'd0;
`endif
    repeat (2) @(posedge clk_i);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 16'd0);
    rst_i = 1'b0;
    step();
    chk_out("post_reset", 1'b0, 1'b0, 1'b0, 16'd0);

    // start and stop together from IDLE: stays IDLE
    start_i = 1'b1;
    stop_i  = 1'b1;
    period_i = 16'd4;
    step();
    chk_out("start_stop", 1'b0, 1'b0, 1'b0, 16'd0);

    // one-shot, period 4
    launch(1'b0, 16'd4);
    chk_out("os4 c1", 1'b1, 1'b0, 1'b0, 16'd0);
    step();
    chk_out("os4 c2", 1'b1, 1'b0, 1'b0, 16'd1);
    step();
    chk_out("os4 c3", 1'b1, 1'b0, 1'b0, 16'd2);
    step();
    chk_out("os4 c4", 1'b1, 1'b1, 1'b0, 16'd3);
    step();
    chk_out("os4 c5", 1'b0, 1'b0, 1'b1, 16'd0);
    step();
    chk_out("os4 c6", 1'b0, 1'b0, 1'b1, 16'd0);
    stop_i = 1'b1;
    step();
    chk_out("done_stop", 1'b0, 1'b0, 1'b0, 16'd0);

    // periodic, period 3, with an ignored start in cycle 5
    exp_cnt = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0};
    exp_tck = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    launch(1'b1, 16'd3);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        start_i  = 1'b1;
        period_i = 16'd7;
      end
      chk_out($sformatf("per3 c%0d", k + 1), 1'b1, exp_tck[k], 1'b0, exp_cnt[k]);
      if (k < 9) step();
    end
    stop_i = 1'b1;
    step();
    chk_out("per3 stop", 1'b0, 1'b0, 1'b0, 16'd0);

    // period 0 behaves as period 1, then restart from DONE with period 2
    launch(1'b0, 16'd0);
    chk_out("p0 c1", 1'b1, 1'b1, 1'b0, 16'd0);
    step();
    chk_out("p0 c2", 1'b0, 1'b0, 1'b1, 16'd0);
    launch(1'b0, 16'd2);
    chk_out("redo c1", 1'b1, 1'b0, 1'b0, 16'd0);
    step();
    chk_out("redo c2", 1'b1, 1'b1, 1'b0, 16'd1);
    step();
    chk_out("redo c3", 1'b0, 1'b0, 1'b1, 16'd0);
    stop_i = 1'b1;
    step();

    // periodic period 5, stop coincides with terminal count
    launch(1'b1, 16'd5);
    for (int k = 1; k <= 4; k++) step();
    stop_i = 1'b1;
    #1;
    chk_out("stop_tc c5", 1'b1, 1'b0, 1'b0, 16'd4);
    step();
    chk_out("stop_tc c6", 1'b0, 1'b0, 1'b0, 16'd0);

    // asynchronous reset mid-run at count 7 of period 10
    launch(1'b1, 16'd10);
    for (int k = 1; k <= 7; k++) step();
    chk_out("pre_rst c8", 1'b1, 1'b0, 1'b0, 16'd7);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 1'b0, 16'd0);
    step();
    rst_i = 1'b0;
    chk_out("rst_held", 1'b0, 1'b0, 1'b0, 16'd0);
    launch(1'b0, 16'd2);
    chk_out("after_rst c1", 1'b1, 1'b0, 1'b0, 16'd0);
    step();
    chk_out("after_rst c2", 1'b1, 1'b1, 1'b0, 16'd1);
    step();
    chk_out("after_rst c3", 1'b0, 1'b0, 1'b1, 16'd0);
    stop_i = 1'b1;
    step();

    // largest period: no wrap, count climbs past the 8-bit boundary
    launch(1'b1, 16'hFFFF);
    for (int k = 1; k <= 300; k++) step();
    chk_out("max_period", 1'b1, 1'b0, 1'b0, 16'd300);
    stop_i = 1'b1;
    step();

`ifdef TIMER_CTRL_PRESCALE_EN
    // prescale 2, period 2: count steps every 3 clocks, tick in cycle 6
    prescale_i = 8'd2;
    launch(1'b0, 16'd2);
    chk_out("ps c1", 1'b1, 1'b0, 1'b0, 16'd0);
    step();
    chk_out("ps c2", 1'b1, 1'b0, 1'b0, 16'd0);
    step();
    chk_out("ps c3", 1'b1, 1'b0, 1'b0, 16'd0);
    step();
    chk_out("ps c4", 1'b1, 1'b0, 1'b0, 16'd1);
    step();
    chk_out("ps c5", 1'b1, 1'b0, 1'b0, 16'd1);
    step();
    chk_out("ps c6", 1'b1, 1'b1, 1'b0, 16'd1);
    step();
    chk_out("ps c7", 1'b0, 1'b0, 1'b1, 16'd0);
    stop_i = 1'b1;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 16, the width of the period and count.
REQ-002 The block SHALL have parameter PRESCALE_WIDTH, default 8, the prescaler width; it is used only when TIMER_CTRL_PRESCALE_EN is defined.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start_i, input, 1 bit: start request pulse.
REQ-006 The block SHALL have port stop_i, input, 1 bit: abort request pulse.
REQ-007 The block SHALL have port mode_i, input, 1 bit: 0 = one-shot, 1 = periodic; sampled on an accepted start.
REQ-008 The block SHALL have port period_i, input, CNT_WIDTH bits: terminal period in counts; sampled on an accepted start.
REQ-009 The block SHALL have port prescale_i, input, PRESCALE_WIDTH bits: divide ratio minus 1; present only with TIMER_CTRL_PRESCALE_EN; sampled on an accepted start.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high while in RUN.
REQ-011 The block SHALL have port tick_o, output, 1 bit: one-cycle terminal-count pulse.
REQ-012 The block SHALL have port done_o, output, 1 bit: high while in DONE (one-shot complete).
REQ-013 The block SHALL have port count_o, output, CNT_WIDTH bits: current count value.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, with the following transitions.
- IDLE to RUN on start_i.
- RUN to IDLE on stop_i.
- RUN to DONE on terminal count when mode = 0.
- DONE to RUN on start_i.
- DONE to IDLE on stop_i.
REQ-015 An accepted start SHALL latch period_i, mode_i and prescale_i and clear the count to 0. If period_i == 0, the latched period SHALL be 1.
REQ-016 Latency: with start_i high in cycle 0, busy_o SHALL be high from cycle 1 and count_o SHALL be 0 in cycle 1.
REQ-017 In RUN, count_o SHALL increment by 1 on every count-enable cycle. The count-enable is every cycle without the prescaler.
REQ-018 Terminal count SHALL be count_o == period-1 on a count-enable cycle. tick_o SHALL be high in exactly that cycle, derived combinationally from registered state.
REQ-019 At terminal count, the count SHALL clear to 0 on the next edge.
- Periodic mode: remain in RUN.
- One-shot mode: enter DONE, with done_o = 1 and busy_o = 0 in the next cycle.
REQ-020 stop_i in RUN SHALL return to IDLE and clear the count. If stop_i and terminal count coincide, stop wins and tick_o SHALL be suppressed.
REQ-021 start_i while in RUN SHALL be ignored, with no relatch and no restart.
REQ-022 start_i and stop_i in the same cycle SHALL resolve as stop: the block goes to, or stays in, IDLE.
REQ-023 In IDLE and DONE, count_o SHALL hold 0 and tick_o SHALL be 0.
REQ-024 The count SHALL never exceed period-1. period = 2^CNT_WIDTH-1 SHALL be handled without overflow.

Reset
REQ-025 rst_i high SHALL immediately force IDLE, count 0, all latched values 0, and the prescaler 0, whether or not it arrives mid-run.
REQ-026 During and after reset, busy_o = 0, tick_o = 0, done_o = 0 and count_o = 0.

Configuration
REQ-027 With TIMER_CTRL_PRESCALE_EN defined, the prescaler and prescale_i SHALL exist.
- Count-enable SHALL fire once every (prescale+1) clocks in RUN.
- The prescaler SHALL restart at 0 on start, stop and terminal count.
REQ-028 Without TIMER_CTRL_PRESCALE_EN, prescale_i and the prescaler SHALL be absent and count-enable SHALL be 1 every RUN cycle.

Structure
REQ-029 Package timer_ctrl_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the mode constants MODE_ONESHOT = 0 and MODE_PERIODIC = 1.
REQ-030 The count register SHALL be an instance of the shared counter module.
- en = count-enable.
- clr = terminal count, or the clear on start/stop.
- Active-low reset port driven by ~rst_i.

Verification
REQ-031 The bench SHALL cover these directed scenarios.
- One-shot, period=4, start in cycle 0: count_o reads 0,1,2,3 in cycles 1-4; tick_o high in cycle 4 only; done_o=1 and busy_o=0 from cycle 5.
- Periodic, period=3, 10 RUN cycles: tick_o in cycles 3, 6 and 9; count_o wraps 2->0.
- period=0, one-shot: tick_o in cycle 1, DONE in cycle 2.
- Periodic, period=5, stop_i in the cycle where count=4: no tick; IDLE and count_o=0 next cycle.
- rst_i asserted at count=7 of period=10: outputs zero asynchronously; start honoured after release.
- With TIMER_CTRL_PRESCALE_EN, prescale=2, period=2: count_o increments every 3 clocks; tick_o in cycle 6.
